// File: rtl/bts_ddr2_rdata_checker.sv
// DDR2 read-data checker: compares valid read beats against parallel
// 32-bit Galois LFSR streams and keeps sticky per-lane error status.
module bts_ddr2_rdata_checker #(
    parameter int local_data_width = 160,
    parameter int num_lanes = 20,
    parameter logic [local_data_width-1:0] prbs_seed_param =
        160'h01234567_89ABCDEF_10111213_45118917_10111213,
    parameter int test_length_bts = 'h800000,
    parameter int test_complete_ctr_width = 24,
    parameter int err_ctr_width = 16,
    parameter int sync_beats = 4
) (
    input  logic                               local_clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               inject_error,
    input  logic                               local_init_done,
    input  logic [local_data_width-1:0]        local_rdata,
    input  logic                               local_rdata_valid,
    input  logic [num_lanes-1:0]               lane_mask,
    output logic                               checking,
    output logic                               pattern_sync_acquired,
    output logic                               test_complete,
    output logic                               error_latch,
    output logic                               error_irq,
    output logic [num_lanes-1:0]               lane_error,
    output logic [err_ctr_width-1:0]           error_count,
    output logic [test_complete_ctr_width-1:0] beat_count
);
    localparam int W  = local_data_width;
    localparam int NS = W / 32;
    localparam int RW = $clog2(sync_beats + 1);
    localparam int CW = test_complete_ctr_width;

    typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             exp_q, exp_d;
    logic                     pend_q, pend_d;
    logic [num_lanes-1:0]     lane_q, lane_d;
    logic                     latch_q, latch_d;
    logic                     irq_q, irq_d;
    logic [err_ctr_width-1:0] errc_q, errc_d;
    logic [CW-1:0]            beats_q, beats_d;
    logic [RW-1:0]            run_q, run_d;
    logic                     sync_q, sync_d;
    logic [W-1:0]             cmp;
    logic [num_lanes-1:0]     lane_hit;
    logic                     beat_err;

    // x^32+x^22+x^2+x+1, one independent register per 32-bit slice
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        logic [W-1:0] n;
        n = '0;
        for (int k = 0; k < NS; k++) begin
            n[32*k+:32] = {s[32*k+:31], 1'b0}
                        ^ (s[32*k+31] ? 32'h0040_0007 : 32'h0);
        end
        return n;
    endfunction

    always_comb begin
        cmp = exp_q ^ {{(W-1){1'b0}}, pend_q};
        lane_hit = '0;
        for (int i = 0; i < num_lanes; i++) begin
            lane_hit[i] = lane_mask[i]
                        && (local_rdata[8*i+:8] != cmp[8*i+:8]);
        end
        beat_err = |lane_hit;
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        pend_d  = pend_q | inject_error;
        lane_d  = lane_q;
        latch_d = latch_q;
        irq_d   = 1'b0;
        errc_d  = errc_q;
        beats_d = beats_q;
        run_d   = run_q;
        sync_d  = sync_q;
        if (start) begin
            state_d = ARMED;
            exp_d   = prbs_seed_param;
            pend_d  = 1'b0;
            lane_d  = '0;
            latch_d = 1'b0;
            errc_d  = '0;
            beats_d = '0;
            run_d   = '0;
            sync_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: if (local_init_done) state_d = CHECK;
                CHECK: if (local_rdata_valid) begin
                    exp_d   = lfsr_next(exp_q);
                    pend_d  = inject_error;
                    beats_d = beats_q + 1'b1;
                    if (beats_d == CW'(test_length_bts)) state_d = DONE;
                    if (beat_err) begin
                        lane_d  = lane_q | lane_hit;
                        latch_d = 1'b1;
                        irq_d   = !latch_q;
                        run_d   = '0;
                        if (errc_q != '1) errc_d = errc_q + 1'b1;
                    end else begin
                        if (run_q != RW'(sync_beats)) run_d = run_q + 1'b1;
                        if (run_q >= RW'(sync_beats - 1)) sync_d = 1'b1;
                    end
                end
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            exp_q   <= prbs_seed_param;
            pend_q  <= 1'b0;
            lane_q  <= '0;
            latch_q <= 1'b0;
            irq_q   <= 1'b0;
            errc_q  <= '0;
            beats_q <= '0;
            run_q   <= '0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
            latch_q <= latch_d;
            irq_q   <= irq_d;
            errc_q  <= errc_d;
            beats_q <= beats_d;
            run_q   <= run_d;
            sync_q  <= sync_d;
        end
    end

    assign checking              = (state_q == CHECK);
    assign test_complete         = (state_q == DONE);
    assign pattern_sync_acquired = sync_q;
    assign error_latch           = latch_q;
    assign error_irq             = irq_q;
    assign lane_error            = lane_q;
    assign error_count           = errc_q;
    assign beat_count            = beats_q;

endmodule

// File: tb/tb_bts_ddr2_rdata_checker.sv
// Randomized and directed bench for bts_ddr2_rdata_checker with an
// in-bench behavioural model compared on every falling clock edge.
module tb_bts_ddr2_rdata_checker;
    localparam int W = 160;
    localparam int NL = 20;
    localparam int TLEN = 24;
    localparam int ECW = 4;
    localparam int EMAX = (1 << ECW) - 1;
    localparam int SYNC = 4;
    localparam logic [W-1:0] SEED =
        160'h01234567_89ABCDEF_10111213_45118917_10111213;
    localparam int M_IDLE = 0, M_ARMED = 1, M_CHECK = 2, M_DONE = 3;

    logic          local_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          inject_error = 1'b0;
    logic          local_init_done = 1'b0;
    logic [W-1:0]  local_rdata = '0;
    logic          local_rdata_valid = 1'b0;
    logic [NL-1:0] lane_mask = '1;
    logic          checking, pattern_sync_acquired, test_complete;
    logic          error_latch, error_irq;
    logic [NL-1:0] lane_error;
    logic [ECW-1:0] error_count;
    logic [23:0]   beat_count;

    int checks = 0;
    int errors = 0;

    bts_ddr2_rdata_checker #(
        .local_data_width(W),
        .num_lanes(NL),
        .prbs_seed_param(SEED),
        .test_length_bts(TLEN),
        .test_complete_ctr_width(24),
        .err_ctr_width(ECW),
        .sync_beats(SYNC)
    ) dut (
        .local_clk(local_clk),
        .reset_n(reset_n),
        .start(start),
        .inject_error(inject_error),
        .local_init_done(local_init_done),
        .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid),
        .lane_mask(lane_mask),
        .checking(checking),
        .pattern_sync_acquired(pattern_sync_acquired),
        .test_complete(test_complete),
        .error_latch(error_latch),
        .error_irq(error_irq),
        .lane_error(lane_error),
        .error_count(error_count),
        .beat_count(beat_count)
    );

    always #5 local_clk = ~local_clk;

    int           m_st;
    logic [W-1:0] m_exp;
    logic         m_pend;
    logic [NL-1:0] m_lane;
    logic         m_latch, m_irq, m_sync;
    int           m_err, m_beats, m_run;

    function automatic logic [31:0] lfsr32(input logic [31:0] s);
        return s[31] ? ((s << 1) ^ 32'h0040_0007) : (s << 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic m_clear();
        m_exp = SEED; m_pend = 0; m_lane = '0; m_latch = 0;
        m_irq = 0; m_err = 0; m_beats = 0; m_run = 0; m_sync = 0;
    endtask

    initial begin
        m_st = M_IDLE;
        m_clear();
        forever begin
            @(posedge local_clk or negedge reset_n);
            if (!reset_n) begin
                m_st = M_IDLE;
                m_clear();
            end else begin
                m_irq = 0;
                if (start) begin
                    m_st = M_ARMED;
                    m_clear();
                end else if (m_st == M_CHECK && local_rdata_valid) begin
                    logic [W-1:0] c;
                    logic [NL-1:0] hit;
                    c = m_exp;
                    c[0] = c[0] ^ m_pend;
                    hit = '0;
                    for (int i = 0; i < NL; i++)
                        if (lane_mask[i] && local_rdata[8*i+:8] != c[8*i+:8])
                            hit[i] = 1'b1;
                    if (hit != '0) begin
                        m_lane = m_lane | hit;
                        if (!m_latch) m_irq = 1;
                        m_latch = 1;
                        if (m_err < EMAX) m_err++;
                        m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run >= SYNC) m_sync = 1;
                    end
                    m_beats++;
                    if (m_beats == TLEN) m_st = M_DONE;
                    for (int k = 0; k < W / 32; k++)
                        m_exp[32*k+:32] = lfsr32(m_exp[32*k+:32]);
                    m_pend = inject_error;
                end else begin
                    m_pend = m_pend | inject_error;
                    if (m_st == M_ARMED && local_init_done) m_st = M_CHECK;
                end
            end
        end
    end

    always @(negedge local_clk) begin
        chk("checking", 64'(checking), 64'(m_st == M_CHECK));
        chk("test_complete", 64'(test_complete), 64'(m_st == M_DONE));
        chk("sync", 64'(pattern_sync_acquired), 64'(m_sync));
        chk("error_latch", 64'(error_latch), 64'(m_latch));
        chk("error_irq", 64'(error_irq), 64'(m_irq));
        chk("lane_error", 64'(lane_error), 64'(m_lane));
        chk("error_count", 64'(error_count), 64'(m_err));
        chk("beat_count", 64'(beat_count), 64'(m_beats));
    end

    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic st, input logic inj);
        local_rdata_valid = v;
        local_rdata = d;
        start = st;
        inject_error = inj;
        @(posedge local_clk);
        #1;
        local_rdata_valid = 0;
        start = 0;
        inject_error = 0;
    endtask

    task automatic good();
        drive(1, m_exp, 0, 0);
    endtask

    task automatic arm();
        local_init_done = 1;
        drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge local_clk);
        #1;
        chk("rst_checking", 64'(checking), 0);
        chk("rst_error_count", 64'(error_count), 0);
        reset_n = 1;

        // eight clean beats
        lane_mask = '1;
        arm();
        for (int b = 1; b <= 8; b++) begin
            good();
            if (b == 3) chk("sync_b3", 64'(pattern_sync_acquired), 0);
            if (b == 4) chk("sync_b4", 64'(pattern_sync_acquired), 1);
        end
        chk("clean_beats", 64'(beat_count), 8);
        chk("clean_errs", 64'(error_count), 0);
        chk("clean_latch", 64'(error_latch), 0);

        // byte 3 corrupted on beat 5
        arm();
        for (int b = 1; b <= 8; b++) begin
            if (b == 5) begin
                drive(1, m_exp ^ (160'h5A << 24), 0, 0);
                chk("b5_lane", 64'(lane_error), 64'h8);
                chk("b5_errs", 64'(error_count), 1);
                chk("b5_irq", 64'(error_irq), 1);
            end else begin
                good();
                if (b == 6) chk("b6_irq", 64'(error_irq), 0);
            end
        end

        // same corruption with lane 3 masked off
        lane_mask = 20'hFFFF7;
        arm();
        for (int b = 1; b <= 8; b++)
            if (b == 5) drive(1, m_exp ^ (160'h5A << 24), 0, 0);
            else good();
        chk("mask_lane", 64'(lane_error), 0);
        chk("mask_errs", 64'(error_count), 0);
        lane_mask = '1;

        // injected error between beats 2 and 3
        arm();
        good();
        good();
        drive(0, '0, 0, 1);
        good();
        chk("inj_lane", 64'(lane_error), 64'h1);
        chk("inj_errs", 64'(error_count), 1);
        repeat (3) good();
        chk("inj_after", 64'(error_count), 1);

        // run to completion and beyond
        arm();
        repeat (TLEN) good();
        chk("done_flag", 64'(test_complete), 1);
        chk("done_beats", 64'(beat_count), TLEN);
        repeat (4) drive(1, ~m_exp, 0, 0);
        chk("done_frozen", 64'(beat_count), TLEN);
        chk("done_noerr", 64'(error_count), 0);

        // error counter saturation, then reset mid-test
        arm();
        repeat (EMAX + 2) drive(1, ~m_exp, 0, 0);
        chk("sat_errs", 64'(error_count), EMAX);
        reset_n = 0;
        #1;
        chk("rst_mid_errs", 64'(error_count), 0);
        chk("rst_mid_beats", 64'(beat_count), 0);
        chk("rst_mid_lane", 64'(lane_error), 0);
        chk("rst_mid_latch", 64'(error_latch), 0);
        chk("rst_mid_chk", 64'(checking), 0);
        @(posedge local_clk);
        #1;
        reset_n = 1;

        // randomized episodes
        for (int e = 0; e < 8; e++) begin
            arm();
            for (int c = 0; c < 80; c++) begin
                logic [W-1:0] d;
                logic v, inj, st;
                local_init_done = ($urandom_range(0, 9) != 0);
                lane_mask = ($urandom_range(0, 3) == 0) ?
                            NL'($urandom) : '1;
                v = ($urandom_range(0, 99) < 65);
                inj = ($urandom_range(0, 19) == 0);
                st = ($urandom_range(0, 59) == 0);
                d = m_exp;
                if ($urandom_range(0, 4) == 0)
                    d = d ^ (160'($urandom_range(1, 255))
                             << (8 * $urandom_range(0, NL - 1)));
                drive(v, d, st, inj);
            end
        end

        @(posedge local_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bts_ddr2_rdata_checker.md
BTS_DDR2_RDATA_CHECKER -- requirements
Module: bts_ddr2_rdata_checker

Interface
REQ-001 SHALL have parameter local_data_width, default 160, read-data bus width; multiple of 32.
REQ-002 SHALL have parameter num_lanes, default 20, byte lanes (local_data_width/8).
REQ-003 SHALL have parameter prbs_seed_param, default 160'h01234567_89ABCDEF_10111213_45118917_10111213, LFSR seed.
REQ-004 SHALL have parameter test_length_bts, default 'h800000, beats checked before completion.
REQ-005 SHALL have parameter test_complete_ctr_width, default 24, beat counter width.
REQ-006 SHALL have parameter err_ctr_width, default 16, error counter width.
REQ-007 SHALL have parameter sync_beats, default 4, consecutive clean beats for sync.
REQ-008 SHALL have port local_clk, input, 1, sole clock; all logic on rising edge.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port start, input, 1, one-cycle pulse that arms a test.
REQ-011 SHALL have port inject_error, input, 1, one-cycle pulse that corrupts the next compare.
REQ-012 SHALL have port local_init_done, input, 1, controller calibration complete.
REQ-013 SHALL have port local_rdata, input, local_data_width, read data from the DDR2 controller.
REQ-014 SHALL have port local_rdata_valid, input, 1, local_rdata qualifier.
REQ-015 SHALL have port lane_mask, input, num_lanes, 1 = lane compared.
REQ-016 SHALL have port checking, output, 1, high in CHECK.
REQ-017 SHALL have port pattern_sync_acquired, output, 1, sticky sync flag.
REQ-018 SHALL have port test_complete, output, 1, high in DONE.
REQ-019 SHALL have port error_latch, output, 1, sticky error flag.
REQ-020 SHALL have port error_irq, output, 1, one-cycle pulse on the first error of a test.
REQ-021 SHALL have port lane_error, output, num_lanes, sticky per-lane error bitmap.
REQ-022 SHALL have port error_count, output, err_ctr_width, count of erroneous beats.
REQ-023 SHALL have port beat_count, output, test_complete_ctr_width, count of checked beats.

Function
REQ-024 SHALL implement states IDLE, ARMED, CHECK and DONE.
REQ-025 In any state, start SHALL go to ARMED, load the expected register with prbs_seed_param, and clear all counters, sticky flags and the sync run.
REQ-026 ARMED SHALL go to CHECK on the first cycle with local_init_done=1; valid beats in ARMED SHALL be ignored.
REQ-027 CHECK SHALL compare each valid beat against the expected register; invalid cycles SHALL change nothing.
REQ-028 Each valid beat SHALL advance the expected register by one step, as local_data_width/32 independent 32-bit Galois LFSRs; polynomial x^32+x^22+x^2+x+1; slice k seeded from seed bits [32k+31:32k].
REQ-029 Lane i SHALL be in error when lane_mask[i]=1 and byte i of local_rdata differs from byte i of expected; a beat is erroneous when any lane is in error.
REQ-030 inject_error SHALL set a pending flag; the next valid beat SHALL compare against expected with bit 0 inverted, then clear the flag.
REQ-031 inject_error coincident with a valid beat SHALL apply to the following beat; the expected register itself SHALL never be corrupted.
REQ-032 lane_error SHALL OR-accumulate; error_latch SHALL set on the first erroneous beat.
REQ-033 error_irq SHALL pulse for exactly one cycle, the cycle after the first erroneous beat.
REQ-034 error_count SHALL increment once per erroneous beat and saturate at all-ones.
REQ-035 beat_count SHALL increment once per valid beat in CHECK.
REQ-036 When a valid beat makes beat_count equal test_length_bts, the state SHALL become DONE; that beat is checked and counted.
REQ-037 In DONE, all status SHALL be frozen and valid beats ignored, until start.
REQ-038 A clean-beat run counter SHALL increment on each clean valid beat and clear on any erroneous beat.
REQ-039 pattern_sync_acquired SHALL set when the run reaches sync_beats and stay set until start or reset.
REQ-040 Outputs SHALL be registered, with 1-cycle latency from the sampled beat.
REQ-041 local_init_done falling in CHECK SHALL have no effect.

Reset
REQ-042 reset_n=0 SHALL asynchronously force IDLE, with all outputs, counters, pending flags and run counter at 0 and expected register at prbs_seed_param.
REQ-043 Reset mid-test SHALL abort the test; no partial status is retained.

Verification
REQ-044 Start, init_done=1, feed 8 correct LFSR beats, mask all-ones -> beat_count=8, error_count=0, sync set after beat 4, error_latch=0.
REQ-045 Corrupt byte 3 of beat 5 -> lane_error=20'h00008, error_count=1, error_irq high one cycle, sync run restarts.
REQ-046 Same as REQ-045 with lane_mask[3]=0 -> no error.
REQ-047 inject_error between beats 2 and 3 -> error on beat 3 only, lane_error bit 0, later beats clean.
REQ-048 test_length_bts=16, 20 beats -> DONE after beat 16, beat_count=16, beats 17-20 ignored.
REQ-049 Force 2^16+2 bad beats with err_ctr_width=16 -> error_count=16'hFFFF; reset_n low mid-test -> all outputs 0 at once.
